bmp_pixel_reader: RTL and testbench

- Pixel source for the image-processing chain; feeds the per-pixel filter stage (colour mask, threshold) that consumes R/G/B, X/Y and a readWrite strobe.
- Scans a BMP image held in a byte-wide, synchronous-read frame memory. Reads BGR byte triplets in bottom-up BMP row order, honouring 4-byte row padding.
- Emits one pixel per strobe in raster order (top-left first), with coordinates, plus a frame-done pulse.

---
 rtl/bmp_reader_pkg.sv | 22 ++
 rtl/bmp_addr_gen.sv | 66 ++++++
 rtl/bmp_pixel_reader.sv | 146 ++++++++++++++
 tb/tb_bmp_pixel_reader.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bmp_reader_pkg.sv
// Shared types and helpers for the BMP frame-memory pixel reader.
// Holds the scan FSM encoding and the padded-row stride derivation.
package bmp_reader_pkg;

   localparam int COORD_W_DEFAULT = 32'sd11;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_RDY = 3'd1,
      RD_B     = 3'd2,
      RD_G     = 3'd3,
      RD_R     = 3'd4,
      CAP_R    = 3'd5,
      EMIT     = 3'd6
   } state_t;

   // BMP rows are padded up to a multiple of four bytes.
   function automatic int row_bytes_of(input int width);
      return ((width * 32'sd3 + 32'sd3) / 32'sd4) * 32'sd4;
   endfunction

endpackage

// File: rtl/bmp_addr_gen.sv
// Pixel coordinate counters and byte pointer for a bottom-up BMP scan.
// The row base walks downward through memory by one padded stride per image row.
module bmp_addr_gen
   import bmp_reader_pkg::*;
#(
   parameter int WIDTH          = 768,
   parameter int HEIGHT         = 512,
   parameter int BMP_HEADER_NUM = 54,
   parameter int ADDR_W         = 21,
   parameter int COORD_W        = COORD_W_DEFAULT,
   parameter int ROW_BYTES      = row_bytes_of(WIDTH)
)(
   input  logic               CAMERA_CLK,
   input  logic               rst,
   input  logic               init,
   input  logic               advance,
   output logic [ADDR_W-1:0]  addr,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic               last_in_row,
   output logic               last_pixel
);

   localparam logic [ADDR_W-1:0]  ROW_STEP  = ADDR_W'(ROW_BYTES);
   localparam logic [ADDR_W-1:0]  FIRST_ROW = ADDR_W'(BMP_HEADER_NUM + (HEIGHT - 32'sd1) * ROW_BYTES);
   localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(WIDTH - 32'sd1);
   localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(HEIGHT - 32'sd1);

   logic [ADDR_W-1:0] row_base;
   logic [ADDR_W-1:0] col_off;

   assign addr        = row_base + col_off;
   assign last_in_row = (x == X_LAST);
   assign last_pixel  = last_in_row && (y == Y_LAST);

   // Counter and pointer update: col_off tracks 3*x incrementally.
   always_ff @(posedge CAMERA_CLK) begin
      if (rst) begin
         x        <= '0;
         y        <= '0;
         row_base <= '0;
         col_off  <= '0;
      end else if (init) begin
         x        <= '0;
         y        <= '0;
         row_base <= FIRST_ROW;
         col_off  <= '0;
      end else if (advance) begin
         if (last_in_row) begin
            x        <= '0;
            y        <= y + COORD_W'(1'b1);
            row_base <= row_base - ROW_STEP;
            col_off  <= '0;
         end else begin
            x        <= x + COORD_W'(1'b1);
            col_off  <= col_off + ADDR_W'(2'd3);
         end
      end else begin
         x        <= x;
         y        <= y;
         row_base <= row_base;
         col_off  <= col_off;
      end
   end

endmodule

// File: rtl/bmp_pixel_reader.sv
// Streams a BMP image from byte-wide frame memory as raster-order RGB pixels.
// Each pixel is three single-byte reads (B, G, R) followed by a one-cycle strobe.
module bmp_pixel_reader
   import bmp_reader_pkg::*;
#(
   parameter int WIDTH          = 768,
   parameter int HEIGHT         = 512,
   parameter int BMP_HEADER_NUM = 54,
   parameter int ADDR_W         = 21,
   parameter int COORD_W        = COORD_W_DEFAULT
)(
   input  logic               CAMERA_CLK,
   input  logic               rst,
   input  logic               start,
   input  logic               sink_ready,
   input  logic [7:0]         mem_rd_data,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               mem_rd_en,
   output logic [7:0]         pixel_R,
   output logic [7:0]         pixel_G,
   output logic [7:0]         pixel_B,
   output logic [COORD_W-1:0] coordinate_X,
   output logic [COORD_W-1:0] coordinate_Y,
   output logic               readWrite,
   output logic               frame_done,
   output logic               busy
);

   localparam int ROW_BYTES = row_bytes_of(WIDTH);

   state_t             state;
   logic [7:0]         b_q;
   logic [7:0]         g_q;
   logic [ADDR_W-1:0]  pix_addr;
   logic [COORD_W-1:0] x;
   logic [COORD_W-1:0] y;
   logic               last_in_row;
   logic               last_pixel;
   logic               init;
   logic               advance;
   logic               frame_end;

   assign init      = (state == IDLE) && start;
   assign advance   = (state == EMIT);
   assign frame_end = last_in_row && last_pixel;

   bmp_addr_gen #(
      .WIDTH          (WIDTH),
      .HEIGHT         (HEIGHT),
      .BMP_HEADER_NUM (BMP_HEADER_NUM),
      .ADDR_W         (ADDR_W),
      .COORD_W        (COORD_W),
      .ROW_BYTES      (ROW_BYTES)
   ) u_addr_gen (
      .CAMERA_CLK  (CAMERA_CLK),
      .rst         (rst),
      .init        (init),
      .advance     (advance),
      .addr        (pix_addr),
      .x           (x),
      .y           (y),
      .last_in_row (last_in_row),
      .last_pixel  (last_pixel)
   );

   // Scan FSM; read data lags mem_rd_en by one cycle, so each byte is captured a state later.
   always_ff @(posedge CAMERA_CLK) begin
      if (rst) begin
         state        <= IDLE;
         mem_addr     <= '0;
         mem_rd_en    <= 1'b0;
         b_q          <= 8'h00;
         g_q          <= 8'h00;
         pixel_R      <= 8'h00;
         pixel_G      <= 8'h00;
         pixel_B      <= 8'h00;
         coordinate_X <= '0;
         coordinate_Y <= '0;
         readWrite    <= 1'b0;
         frame_done   <= 1'b0;
         busy         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  busy  <= 1'b1;
                  state <= WAIT_RDY;
               end else begin
                  state <= IDLE;
               end
            end
            WAIT_RDY: begin
               if (sink_ready) begin
                  mem_addr  <= pix_addr;
                  mem_rd_en <= 1'b1;
                  state     <= RD_B;
               end else begin
                  state <= WAIT_RDY;
               end
            end
            RD_B: begin
               mem_addr <= mem_addr + ADDR_W'(1'b1);
               state    <= RD_G;
            end
            RD_G: begin
               b_q      <= mem_rd_data;
               mem_addr <= mem_addr + ADDR_W'(1'b1);
               state    <= RD_R;
            end
            RD_R: begin
               g_q       <= mem_rd_data;
               mem_rd_en <= 1'b0;
               state     <= CAP_R;
            end
            CAP_R: begin
               pixel_R      <= mem_rd_data;
               pixel_G      <= g_q;
               pixel_B      <= b_q;
               coordinate_X <= x;
               coordinate_Y <= y;
               readWrite    <= 1'b1;
               frame_done   <= frame_end;
               state        <= EMIT;
            end
            EMIT: begin
               readWrite  <= 1'b0;
               frame_done <= 1'b0;
               if (frame_end) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  state <= WAIT_RDY;
               end
            end
            default: begin
               mem_rd_en  <= 1'b0;
               readWrite  <= 1'b0;
               frame_done <= 1'b0;
               busy       <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bmp_pixel_reader.sv
// Self-checking bench: three reader instances (4x2, 5x2 padded, 768x512) over modelled frame memories.
module tb_bmp_pixel_reader;

   localparam int AW = 4;
   localparam int AH = 2;
   localparam int PW = 5;
   localparam int PH = 2;
   localparam int DW = 768;
   localparam int DH = 512;

   typedef struct {
      int         x;
      int         y;
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
      logic       fd;
      int         cyc;
   } strobe_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, sink_ready, a_start, p_start, d_start;
   logic [20:0] a_addr, p_addr, d_addr;
   logic a_en, p_en, d_en;
   logic [7:0] a_rd = 8'h00, p_rd = 8'h00, d_rd = 8'h00;
   logic [7:0] a_R, a_G, a_B, p_R, p_G, p_B, d_R, d_G, d_B;
   logic [10:0] a_X, a_Y, p_X, p_Y, d_X, d_Y;
   logic a_rw, a_fd, a_busy, p_rw, p_fd, p_busy, d_rw, d_fd, d_busy;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   logic [7:0] key = 8'h00;
   strobe_t a_q[$];
   int a_first = -1, p_first = -1, d_first = -1;
   int a_fd_cnt = 0, p_cnt = 0;

   bmp_pixel_reader #(.WIDTH(AW), .HEIGHT(AH)) dut_a (
      .CAMERA_CLK(clk), .rst(rst), .start(a_start), .sink_ready(sink_ready), .mem_rd_data(a_rd),
      .mem_addr(a_addr), .mem_rd_en(a_en), .pixel_R(a_R), .pixel_G(a_G), .pixel_B(a_B),
      .coordinate_X(a_X), .coordinate_Y(a_Y), .readWrite(a_rw), .frame_done(a_fd), .busy(a_busy));

   bmp_pixel_reader #(.WIDTH(PW), .HEIGHT(PH)) dut_p (
      .CAMERA_CLK(clk), .rst(rst), .start(p_start), .sink_ready(sink_ready), .mem_rd_data(p_rd),
      .mem_addr(p_addr), .mem_rd_en(p_en), .pixel_R(p_R), .pixel_G(p_G), .pixel_B(p_B),
      .coordinate_X(p_X), .coordinate_Y(p_Y), .readWrite(p_rw), .frame_done(p_fd), .busy(p_busy));

   bmp_pixel_reader dut_d (
      .CAMERA_CLK(clk), .rst(rst), .start(d_start), .sink_ready(sink_ready), .mem_rd_data(d_rd),
      .mem_addr(d_addr), .mem_rd_en(d_en), .pixel_R(d_R), .pixel_G(d_G), .pixel_B(d_B),
      .coordinate_X(d_X), .coordinate_Y(d_Y), .readWrite(d_rw), .frame_done(d_fd), .busy(d_busy));

   function automatic logic [7:0] mem_byte(input int a);
      return a[7:0] ^ key;
   endfunction

   // Byte address of the blue byte of pixel (x,y) in a bottom-up, 4-byte-padded BMP.
   function automatic int pix_base(input int x, input int y, input int w, input int h);
      return 54 + (h - 1 - y) * (((w * 3 + 3) / 4) * 4) + 3 * x;
   endfunction

   function automatic bit legal(input int a, input int w, input int h);
      int rb, off;
      rb  = ((w * 3 + 3) / 4) * 4;
      off = a - 54;
      if (a < 54) return 1'b0;
      return (off / rb < h) && (off % rb < 3 * w);
   endfunction

   always @(posedge clk) cyc++;
   always @(posedge clk) if (a_en) a_rd <= mem_byte(int'(a_addr));
   always @(posedge clk) if (p_en) p_rd <= mem_byte(int'(p_addr));
   always @(posedge clk) if (d_en) d_rd <= mem_byte(int'(d_addr));

   always @(negedge clk) begin
      if (a_rw) a_q.push_back('{x: int'(a_X), y: int'(a_Y), r: a_R, g: a_G, b: a_B, fd: a_fd, cyc: cyc});
      if (a_en && a_first < 0) a_first = int'(a_addr);
      if (p_en && p_first < 0) p_first = int'(p_addr);
      if (d_en && d_first < 0) d_first = int'(d_addr);
      if (p_rw) p_cnt++;
      if (a_fd) begin
         a_fd_cnt++;
         n_chk++;
         if (a_rw !== 1'b1) begin n_fail++; $display("FAIL fd_with_strobe: readWrite=%b when frame_done=1, need 1", a_rw); end
      end
      if (a_en) begin
         n_chk++;
         if (!legal(int'(a_addr), AW, AH)) begin n_fail++; $display("FAIL a_read_legal: addr %0d read, need pixel byte", a_addr); end
      end
      if (p_en) begin
         n_chk++;
         if (!legal(int'(p_addr), PW, PH)) begin n_fail++; $display("FAIL p_read_legal: addr %0d read, need pixel byte", p_addr); end
      end
   end

   task automatic test_reset();
      rst = 1'b1; a_start = 1'b0; p_start = 1'b0; d_start = 1'b0; sink_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_chk++;
      if ({a_addr, a_en, a_R, a_G, a_B, a_X, a_Y, a_rw, a_fd, a_busy} !== '0) begin
         n_fail++; $display("FAIL reset_a: outputs %h, need 0", {a_addr, a_en, a_R, a_G, a_B, a_X, a_Y, a_rw, a_fd, a_busy});
      end
      n_chk++;
      if ({p_addr, p_en, p_R, p_G, p_B, p_X, p_Y, p_rw, p_fd, p_busy} !== '0) begin
         n_fail++; $display("FAIL reset_p: outputs %h, need 0", {p_addr, p_en, p_R, p_G, p_B, p_X, p_Y, p_rw, p_fd, p_busy});
      end
      n_chk++;
      if ({d_addr, d_en, d_R, d_G, d_B, d_X, d_Y, d_rw, d_fd, d_busy} !== '0) begin
         n_fail++; $display("FAIL reset_d: outputs %h, need 0", {d_addr, d_en, d_R, d_G, d_B, d_X, d_Y, d_rw, d_fd, d_busy});
      end
      rst = 1'b0;
   endtask

   task automatic test_frame();
      int t, s, ex, ey, base;
      key = 8'h00; sink_ready = 1'b1; a_q.delete(); p_cnt = 0; a_first = -1; p_first = -1;
      @(negedge clk); a_start = 1'b1; p_start = 1'b1; s = cyc;
      @(negedge clk); a_start = 1'b0; p_start = 1'b0;
      n_chk++;
      if (a_busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start: %b, need 1", a_busy); end
      t = 0;
      while (a_fd !== 1'b1 && t < 500) begin @(negedge clk); t++; end
      n_chk++;
      if (t >= 500) begin n_fail++; $display("FAIL frame_timeout: %0d cycles, need <500", t); end
      @(negedge clk);
      n_chk++;
      if (a_busy !== 1'b0) begin n_fail++; $display("FAIL busy_after_done: %b, need 0", a_busy); end
      n_chk++;
      if (a_q.size() != AW * AH) begin n_fail++; $display("FAIL strobe_count: %0d, need %0d", a_q.size(), AW * AH); end
      n_chk++;
      if (a_first != 66) begin n_fail++; $display("FAIL first_addr: %0d, need 66", a_first); end
      for (int i = 0; i < a_q.size(); i++) begin
         ex = i % AW; ey = i / AW; base = pix_base(ex, ey, AW, AH);
         n_chk++;
         if (a_q[i].x != ex || a_q[i].y != ey || a_q[i].b !== mem_byte(base) || a_q[i].g !== mem_byte(base + 1)
             || a_q[i].r !== mem_byte(base + 2) || a_q[i].fd !== (i == AW * AH - 1)) begin
            n_fail++;
            $display("FAIL pixel_%0d: (%0d,%0d) BGR %0d/%0d/%0d fd %b, need (%0d,%0d) %0d/%0d/%0d fd %b", i,
                     a_q[i].x, a_q[i].y, a_q[i].b, a_q[i].g, a_q[i].r, a_q[i].fd, ex, ey,
                     mem_byte(base), mem_byte(base + 1), mem_byte(base + 2), i == AW * AH - 1);
         end
      end
      if (a_q.size() == AW * AH) begin
         n_chk++;
         if (a_q[0].b !== 8'd66 || a_q[0].g !== 8'd67 || a_q[0].r !== 8'd68 || a_q[3].b !== 8'd75
             || a_q[4].b !== 8'd54 || a_q[4].g !== 8'd55 || a_q[4].r !== 8'd56 || a_q[7].b !== 8'd63) begin
            n_fail++; $display("FAIL known_bytes: %0d %0d %0d %0d %0d %0d %0d %0d, need 66 67 68 75 54 55 56 63",
                               a_q[0].b, a_q[0].g, a_q[0].r, a_q[3].b, a_q[4].b, a_q[4].g, a_q[4].r, a_q[7].b);
         end
         n_chk++;
         if (a_q[0].cyc - s != 6) begin n_fail++; $display("FAIL start_latency: %0d, need 6", a_q[0].cyc - s); end
      end
      t = 0;
      while (p_busy === 1'b1 && t < 500) begin @(negedge clk); t++; end
      n_chk++;
      if (p_first != 70) begin n_fail++; $display("FAIL pad_first_addr: %0d, need 70", p_first); end
      n_chk++;
      if (p_cnt != PW * PH) begin n_fail++; $display("FAIL pad_strobes: %0d, need %0d", p_cnt, PW * PH); end
   endtask

   task automatic test_stall();
      int t, s;
      sink_ready = 1'b1;
      @(negedge clk); a_start = 1'b1;
      @(negedge clk); a_start = 1'b0;
      t = 0;
      while (a_rw !== 1'b1 && t < 100) begin @(negedge clk); t++; end
      sink_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_chk++;
         if (a_en !== 1'b0 || a_rw !== 1'b0) begin n_fail++; $display("FAIL stall_idle_%0d: en=%b rw=%b, need 0 0", i, a_en, a_rw); end
      end
      sink_ready = 1'b1; s = cyc;
      t = 0;
      while (a_rw !== 1'b1 && t < 100) begin @(negedge clk); t++; end
      n_chk++;
      if (cyc - s != 5 || a_X !== 11'd1 || a_Y !== 11'd0) begin
         n_fail++; $display("FAIL stall_resume: latency %0d X %0d Y %0d, need 5 1 0", cyc - s, a_X, a_Y);
      end
      t = 0;
      while (a_busy === 1'b1 && t < 500) begin @(negedge clk); t++; end
   endtask

   task automatic test_reset_mid();
      int t, f0;
      sink_ready = 1'b1; f0 = a_fd_cnt;
      @(negedge clk); a_start = 1'b1;
      @(negedge clk); a_start = 1'b0;
      t = 0;
      while (!(a_en === 1'b1 && a_addr === 21'd73) && t < 200) begin @(negedge clk); t++; end
      rst = 1'b1;
      @(negedge clk);
      n_chk++;
      if ({a_addr, a_en, a_R, a_G, a_B, a_X, a_Y, a_rw, a_fd, a_busy} !== '0) begin
         n_fail++; $display("FAIL reset_mid: outputs %h, need 0", {a_addr, a_en, a_R, a_G, a_B, a_X, a_Y, a_rw, a_fd, a_busy});
      end
      rst = 1'b0;
      repeat (5) @(negedge clk);
      n_chk++;
      if (a_fd_cnt != f0) begin n_fail++; $display("FAIL reset_no_done: %0d frame_done pulses, need %0d", a_fd_cnt, f0); end
      a_first = -1; a_q.delete();
      a_start = 1'b1;
      @(negedge clk); a_start = 1'b0;
      t = 0;
      while (a_fd !== 1'b1 && t < 500) begin @(negedge clk); t++; end
      @(negedge clk);
      n_chk++;
      if (a_first != 66 || a_q.size() != AW * AH) begin
         n_fail++; $display("FAIL restart: first addr %0d strobes %0d, need 66 %0d", a_first, a_q.size(), AW * AH);
      end
      if (a_q.size() > 0) begin
         n_chk++;
         if (a_q[0].x != 0 || a_q[0].y != 0 || a_q[0].b !== 8'd66) begin
            n_fail++; $display("FAIL restart_pixel0: (%0d,%0d) B %0d, need (0,0) 66", a_q[0].x, a_q[0].y, a_q[0].b);
         end
      end
   endtask

   task automatic test_start_ignored();
      int t;
      sink_ready = 1'b1; a_q.delete();
      @(negedge clk); a_start = 1'b1;
      @(negedge clk); a_start = 1'b0;
      t = 0;
      while (a_q.size() < 3 && t < 200) begin @(negedge clk); t++; end
      a_start = 1'b1;
      @(negedge clk); a_start = 1'b0;
      t = 0;
      while (a_fd !== 1'b1 && t < 500) begin @(negedge clk); t++; end
      a_start = 1'b1;
      @(negedge clk); a_start = 1'b0;
      n_chk++;
      if (a_busy !== 1'b0) begin n_fail++; $display("FAIL busy_cleared: %b, need 0", a_busy); end
      repeat (20) @(negedge clk);
      n_chk++;
      if (a_q.size() != AW * AH || a_busy !== 1'b0) begin
         n_fail++; $display("FAIL start_ignored: strobes %0d busy %b, need %0d 0", a_q.size(), a_busy, AW * AH);
      end
   endtask

   task automatic test_back_to_back();
      int t, ex, ey, base;
      key = 8'($urandom);
      @(negedge clk);
      for (int f = 0; f < 3; f++) begin
         a_q.delete();
         a_start = 1'b1;
         @(negedge clk); a_start = 1'b0;
         t = 0;
         while (a_fd !== 1'b1 && t < 2000) begin
            @(negedge clk);
            sink_ready = ($urandom_range(0, 3) != 0);
            t++;
         end
         @(negedge clk);
         n_chk++;
         if (a_q.size() != AW * AH || a_busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_frame_%0d: strobes %0d busy %b, need %0d 0", f, a_q.size(), a_busy, AW * AH);
         end
         for (int i = 0; i < a_q.size(); i++) begin
            ex = i % AW; ey = i / AW; base = pix_base(ex, ey, AW, AH);
            n_chk++;
            if (a_q[i].x != ex || a_q[i].y != ey || a_q[i].b !== mem_byte(base)
                || a_q[i].g !== mem_byte(base + 1) || a_q[i].r !== mem_byte(base + 2)) begin
               n_fail++;
               $display("FAIL b2b_%0d_pixel_%0d: (%0d,%0d) BGR %0d/%0d/%0d, need (%0d,%0d) %0d/%0d/%0d", f, i,
                        a_q[i].x, a_q[i].y, a_q[i].b, a_q[i].g, a_q[i].r, ex, ey,
                        mem_byte(base), mem_byte(base + 1), mem_byte(base + 2));
            end
         end
         @(negedge clk);
      end
      sink_ready = 1'b1;
   endtask

   task automatic test_default_size();
      int t, base;
      key = 8'h00; sink_ready = 1'b1; d_first = -1;
      base = pix_base(0, 0, DW, DH);
      @(negedge clk); d_start = 1'b1;
      @(negedge clk); d_start = 1'b0;
      t = 0;
      while (d_rw !== 1'b1 && t < 50) begin @(negedge clk); t++; end
      n_chk++;
      if (d_first != 1177398 || d_first != base) begin n_fail++; $display("FAIL default_first_addr: %0d, need 1177398", d_first); end
      n_chk++;
      if (d_X !== 11'd0 || d_Y !== 11'd0 || d_B !== mem_byte(base) || d_G !== mem_byte(base + 1)
          || d_R !== mem_byte(base + 2) || d_busy !== 1'b1) begin
         n_fail++; $display("FAIL default_pixel0: (%0d,%0d) BGR %0d/%0d/%0d busy %b, need (0,0) %0d/%0d/%0d 1",
                            d_X, d_Y, d_B, d_G, d_R, d_busy, mem_byte(base), mem_byte(base + 1), mem_byte(base + 2));
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_frame();
      test_stall();
      test_reset_mid();
      test_start_ignored();
      test_back_to_back();
      test_default_size();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
